// File: rtl/ccff_loader.sv
// ccff_loader: takes bitstream words from a valid/ready stream, shifts them
// MSB-first into the fabric configuration chain, and gates prog_clk so the
// chain only moves on real bits. Bits falling out of ccff_tail on those same
// shifts are packed into readback words.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no session; stream not accepted, waiting for start
// LOAD  | session running; words accepted and shifted into the chain
// DONE  | single-cycle completion pulse, then back to IDLE

module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int                PW      = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LEN_C   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  WORD_C  = CNT_W'(WORD_W);
  localparam logic [PW-1:0]     FULL_P  = PW'(WORD_W);
  localparam logic [WORD_W-1:0] PTR_MSB = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Serialiser: sr holds bits still to be presented (next one at the MSB),
  // pend counts them; head/en are the registered chain-side outputs.
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [PW-1:0]     pend_q, pend_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;

  // Readback: rb_ptr is a one-hot marking the slot the next tail bit fills,
  // so a word cut short by the chain end is already left-aligned.
  logic [WORD_W-1:0] rb_sh_q, rb_sh_d;
  logic [WORD_W-1:0] rb_ptr_q, rb_ptr_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  logic              start_ok;
  logic              xfer;
  logic              last_bit;
  logic [CNT_W-1:0]  rem_bits;
  logic [PW-1:0]     take_bits;
  logic [WORD_W-1:0] rb_word;

  // Handshake, end-of-chain detect, and how many bits of a new word are used.
  always_comb begin
    start_ok  = (state_q == ST_IDLE) && start;
    xfer      = s_valid && s_ready;
    last_bit  = en_q && (bit_cnt_q == LAST_C);
    rem_bits  = LEN_C - acc_cnt_q;
    take_bits = (rem_bits >= WORD_C) ? FULL_P : rem_bits[PW-1:0];
    rb_word   = rb_sh_q | (rb_ptr_q & {WORD_W{ccff_tail}});
  end

  // FSM state register.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: only IDLE honours start; the final shift ends LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; s_ready opens when nothing is pending beyond the bit on head.
  always_comb begin
    busy        = (state_q == ST_LOAD);
    done        = (state_q == ST_DONE);
    s_ready     = (state_q == ST_LOAD) && (acc_cnt_q < LEN_C) && (pend_q == '0);
    ccff_head   = head_q;
    prog_clk_en = en_q;
    rb_data     = rb_data_q;
    rb_valid    = rb_valid_q;
  end

  // Datapath next-state: serialise words, count shifts, assemble readback.
  always_comb begin
    sr_d       = sr_q;
    pend_d     = pend_q;
    head_d     = head_q;
    en_d       = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    rb_sh_d    = rb_sh_q;
    rb_ptr_d   = rb_ptr_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;

    if (start_ok) begin
      sr_d      = '0;
      pend_d    = '0;
      bit_cnt_d = '0;
      acc_cnt_d = '0;
      rb_sh_d   = '0;
      rb_ptr_d  = PTR_MSB;
    end else begin
      if (en_q) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end

      if (en_q && (pend_q != '0)) begin
        head_d = sr_q[WORD_W-1];
        sr_d   = sr_q << 1;
        pend_d = pend_q - PW'(1);
        en_d   = 1'b1;
      end else if (xfer) begin
        // A short final word keeps only its leading bits; the rest never
        // reach the chain because pend stops short of them.
        head_d    = s_data[WORD_W-1];
        sr_d      = s_data << 1;
        pend_d    = take_bits - PW'(1);
        acc_cnt_d = acc_cnt_q + CNT_W'(take_bits);
        en_d      = 1'b1;
      end

      if (en_q) begin
        if (rb_ptr_q[0] || last_bit) begin
          rb_data_d  = rb_word;
          rb_valid_d = 1'b1;
          rb_sh_d    = '0;
          rb_ptr_d   = PTR_MSB;
        end else begin
          rb_sh_d  = rb_word;
          rb_ptr_d = rb_ptr_q >> 1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sr_q       <= '0;
      pend_q     <= '0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
      bit_cnt_q  <= '0;
      acc_cnt_q  <= '0;
      rb_sh_q    <= '0;
      rb_ptr_q   <= PTR_MSB;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      pend_q     <= pend_d;
      head_q     <= head_d;
      en_q       <= en_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      rb_sh_q    <= rb_sh_d;
      rb_ptr_q   <= rb_ptr_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain driver for the FPGA fabric: accepts bitstream words on a valid/ready stream, serialises them MSB-first onto `ccff_head` of the first tile in the configuration chain, and gates `prog_clk` so the chain shifts only on valid bits. Bits that leave the chain on `ccff_tail` are captured on the same shifts and returned as readback words, so the previous contents can be verified. It sits between the SoC-side bitstream source and the `ccff_head`/`ccff_tail` ends of the grid's configuration chain.

## Interface
Parameters:
- `CHAIN_LEN`, 64: total configuration bits in the chain, ≥1.
- `WORD_W`, 8: bitstream and readback word width, ≥2.
- `CNT_W`, 16: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `prog_clk`  in  1: programming clock; everything is on its rising edge.
- `pReset_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: single-cycle request to begin a load session. Ignored while `busy`=1.
- `busy`  out  1: a session is in progress.
- `done`  out  1: one-cycle pulse when the session completes.
- `s_data`  in  WORD_W: bitstream word. `s_data[WORD_W-1]` is shifted first.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the loader accepts `s_data` this cycle.
- `ccff_head`  out  1: serial data into the chain, registered.
- `prog_clk_en`  out  1: enable for the top-level clock gate on the chain's `prog_clk`. The chain captures `ccff_head` on an edge only if `prog_clk_en`=1 in the cycle before that edge.
- `ccff_tail`  in  1: serial data out of the chain's last flop.
- `rb_data`  out  WORD_W: readback word, first bit out of the chain in the MSB.
- `rb_valid`  out  1: one-cycle pulse; `rb_data` is valid. There is no backpressure.

## Operation
- FSM states:
  - IDLE: `busy`=0, `s_ready`=0. A `start` pulse moves the FSM to LOAD and clears the bit counter, the shift register, and the readback assembly register.
  - LOAD: `busy`=1. Words are accepted and shifted out as described below.
  - DONE: lasts one cycle. `done`=1 and `busy`=0, then the FSM returns to IDLE.
- Shift register holds up to WORD_W pending bits, plus a count of remaining bits.
- `s_ready`=1 in LOAD when fewer than CHAIN_LEN bits have been accepted so far and either:
  - the shift register is empty, or
  - the shift register is presenting its last pending bit this cycle.
- Because of that rule, back-to-back words stream with no gap.
- A transfer is `s_valid`&&`s_ready` at an edge. It loads the word and its first bit (MSB) appears on `ccff_head` in the following cycle.
- `prog_clk_en`=1 exactly in cycles where `ccff_head` carries an unconsumed bit. Each such cycle consumes one bit and increments the bit counter.
- With no word pending, `prog_clk_en`=0 and `ccff_head` holds its last value. The chain does not shift.
- Last word when CHAIN_LEN mod WORD_W = r ≠ 0: only its r MSBs are shifted. The remaining bits are discarded and no further words are accepted.
- Readback:
  - On every enabled cycle, `ccff_tail` is shifted into the readback register (MSB first).
  - After WORD_W captured bits, `rb_valid` pulses for one cycle and `rb_data` is updated.
  - After the final chain bit, a partial word is emitted left-aligned with the low bits zero.
- The counter reaching CHAIN_LEN on the final enabled cycle moves the FSM to DONE on the next edge.
- After a completed session the chain holds the accepted bits. The first bit sent sits in the chain's last flop.

## Timing
- Reset values: `busy`=0, `done`=0, `s_ready`=0, `ccff_head`=0, `prog_clk_en`=0, `rb_data`=0, `rb_valid`=0, FSM in IDLE.
- Reset mid-session:
  - Asynchronous assertion clears all state and drives `prog_clk_en` low immediately.
  - The partially loaded chain is not restored.
  - The next session restarts from bit 0.
- `start` sampled at edge e0 → `busy`=1 and `s_ready`=1 from cycle e0+1.
- First accept at edge a → `ccff_head`=MSB and `prog_clk_en`=1 in cycle a+1.
- With continuous `s_valid`, `prog_clk_en` stays high for CHAIN_LEN consecutive cycles. `done` pulses in the cycle after the last enabled cycle.
- `rb_valid` for word k pulses in the cycle after the enabled cycle that captured its last bit.
- `start` asserted in the DONE cycle is ignored; only IDLE accepts `start`.
- `s_valid` may drop at any time. This only inserts stall cycles with `prog_clk_en`=0; bit ordering is unchanged.

## Test plan
- CHAIN_LEN=64, WORD_W=8: stream 0xA5,0x3C,0x01,0x80,0xFF,0x00,0x5A,0xC3 back-to-back → `prog_clk_en` high for 64 consecutive cycles; `ccff_head` carries the bits MSB-first; `done` pulses once; a 64-flop behavioural chain holds the pattern with 0xA5's MSB in the last flop.
- Load the pattern above, then run a second session with eight 0x00 words → the 8 `rb_valid` pulses carry 0xA5,0x3C,…,0xC3 in order; the chain reads all zero.
- Insert 3 idle `s_valid` cycles between every word → `prog_clk_en` is low during the gaps; `ccff_head` is held; final chain contents and readback are identical to the first scenario.
- CHAIN_LEN=20, WORD_W=8, words 0xFF,0xFF,0x9F:
  - `s_ready` stays low after the third accept.
  - Exactly 20 enabled cycles occur; the last four shifted bits are 1,0,0,1.
  - The third `rb_data` is left-aligned with its low 4 bits zero.
- Drive `pReset_n` low after 30 of 64 bits → all outputs go to reset values without waiting for a clock edge. A new `start` then requires the full 64 bits before `done`.
- Pulse `start` while `busy`=1 and in the DONE cycle → no effect. Pulse `start` in IDLE with `s_valid` already high → the first accept occurs at e0+1.
